// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, WB control bit indices
// and the MEM/WB entry layout carried through the stage register.
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam int WB_REGWRITE = 0;
    localparam int WB_MEMTOREG = 1;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [DATA_W-1:0]     mem_rdata;
        logic [DATA_W-1:0]     alu_res;
        logic [REG_ADDR_W-1:0] wr_addr;
        logic                  jump;
        logic [DATA_W-1:0]     jump_target;
        logic [DATA_W-1:0]     wb_data;
    } memwb_entry_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic two-entry valid/ready skid buffer with synchronous flush.
// in_ready is a registered function of the skid entry only.
module pipe_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             head_valid_reg, head_valid_next;
    logic             skid_valid_reg, skid_valid_next;
    logic [WIDTH-1:0] head_data_reg, head_data_next;
    logic [WIDTH-1:0] skid_data_reg, skid_data_next;
    logic             acc;
    logic             cons;

    assign acc  = in_valid && !skid_valid_reg;
    assign cons = head_valid_reg && out_ready;

    always_comb begin
        head_valid_next = head_valid_reg;
        skid_valid_next = skid_valid_reg;
        head_data_next  = head_data_reg;
        skid_data_next  = skid_data_reg;
        if (flush) begin
            // Data fields are left stale; only the valid bits matter.
            head_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (!head_valid_reg) begin
            if (acc) begin
                head_valid_next = 1'b1;
                head_data_next  = in_data;
            end
        end else if (cons) begin
            if (skid_valid_reg) begin
                head_data_next  = skid_data_reg;
                skid_valid_next = 1'b0;
            end else if (acc) begin
                head_data_next  = in_data;
            end else begin
                head_valid_next = 1'b0;
            end
        end else if (acc) begin
            skid_valid_next = 1'b1;
            skid_data_next  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            head_data_reg  <= '0;
            skid_data_reg  <= '0;
        end else begin
            head_valid_reg <= head_valid_next;
            skid_valid_reg <= skid_valid_next;
            head_data_reg  <= head_data_next;
            skid_data_reg  <= skid_data_next;
        end
    end

    assign in_ready  = !skid_valid_reg;
    assign out_valid = head_valid_reg;
    assign out_data  = head_data_reg;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage register with handshake, skid buffer, flush and pre-selected
// writeback data. Define MEMWB_FWD_EN to add the fwd_* forwarding outputs.
module mem_wb_stage #(
    parameter int DATA_W            = mips_pkg::DATA_W,
    parameter int REG_ADDR_W        = mips_pkg::REG_ADDR_W,
    parameter bit ZERO_REG_SUPPRESS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_wb,
    input  logic [DATA_W-1:0]     in_mem_rdata,
    input  logic [DATA_W-1:0]     in_alu_res,
    input  logic [REG_ADDR_W-1:0] in_wr_addr,
    input  logic                  in_jump,
    input  logic [DATA_W-1:0]     in_jump_target,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_reg_write,
    output logic                  out_mem_to_reg,
    output logic [DATA_W-1:0]     out_mem_rdata,
    output logic [DATA_W-1:0]     out_alu_res,
    output logic [REG_ADDR_W-1:0] out_wr_addr,
    output logic                  out_jump,
    output logic [DATA_W-1:0]     out_jump_target,
`ifdef MEMWB_FWD_EN
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0]     fwd_data,
`endif
    output logic [DATA_W-1:0]     out_wb_data
);

    import mips_pkg::*;

    localparam int ENTRY_W = $bits(memwb_entry_t);

    memwb_entry_t        in_entry;
    memwb_entry_t        head_entry;
    logic [ENTRY_W-1:0]  head_bits;
    logic                wr_addr_is_zero;

    assign wr_addr_is_zero = (in_wr_addr == '0);

    always_comb begin
        in_entry             = '0;
        in_entry.mem_to_reg  = in_wb[WB_MEMTOREG];
        in_entry.mem_rdata   = in_mem_rdata;
        in_entry.alu_res     = in_alu_res;
        in_entry.wr_addr     = in_wr_addr;
        in_entry.jump        = in_jump;
        in_entry.jump_target = in_jump_target;
        // Writeback value is chosen once at capture so WB sees a plain register.
        in_entry.wb_data     = in_wb[WB_MEMTOREG] ? in_mem_rdata : in_alu_res;
        if (ZERO_REG_SUPPRESS)
            in_entry.reg_write = in_wb[WB_REGWRITE] && !wr_addr_is_zero;
        else
            in_entry.reg_write = in_wb[WB_REGWRITE];
    end

    pipe_skid_reg #(
        .WIDTH (ENTRY_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_bits)
    );

    assign head_entry      = memwb_entry_t'(head_bits);
    assign out_reg_write   = head_entry.reg_write;
    assign out_mem_to_reg  = head_entry.mem_to_reg;
    assign out_mem_rdata   = head_entry.mem_rdata;
    assign out_alu_res     = head_entry.alu_res;
    assign out_wr_addr     = head_entry.wr_addr;
    assign out_jump        = head_entry.jump;
    assign out_jump_target = head_entry.jump_target;
    assign out_wb_data     = head_entry.wb_data;

`ifdef MEMWB_FWD_EN
    assign fwd_valid = out_valid && out_reg_write;
    assign fwd_addr  = out_wr_addr;
    assign fwd_data  = out_wb_data;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised and directed bench for mem_wb_stage against a 2-deep FIFO model.
// Build with MEMWB_FWD_EN defined to also exercise the forwarding outputs.
module tb_mem_wb_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        bit          reg_write;
        bit          mem_to_reg;
        bit [DW-1:0] mem_rdata;
        bit [DW-1:0] alu_res;
        bit [AW-1:0] wr_addr;
        bit          jump;
        bit [DW-1:0] jump_target;
        bit [DW-1:0] wb_data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [1:0]    in_wb = '0;
    logic [DW-1:0] in_mem_rdata = '0;
    logic [DW-1:0] in_alu_res = '0;
    logic [AW-1:0] in_wr_addr = '0;
    logic          in_jump = 1'b0;
    logic [DW-1:0] in_jump_target = '0;
    logic          out_ready = 1'b0;

    logic          in_ready, out_valid, out_reg_write, out_mem_to_reg, out_jump;
    logic [DW-1:0] out_mem_rdata, out_alu_res, out_jump_target, out_wb_data;
    logic [AW-1:0] out_wr_addr;

    logic          nz_in_ready, nz_out_valid, nz_out_reg_write, nz_out_mem_to_reg, nz_out_jump;
    logic [DW-1:0] nz_out_mem_rdata, nz_out_alu_res, nz_out_jump_target, nz_out_wb_data;
    logic [AW-1:0] nz_out_wr_addr;

`ifdef MEMWB_FWD_EN
    logic          fwd_valid, nz_fwd_valid;
    logic [AW-1:0] fwd_addr, nz_fwd_addr;
    logic [DW-1:0] fwd_data, nz_fwd_data;
`endif

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .ZERO_REG_SUPPRESS(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_wb(in_wb), .in_mem_rdata(in_mem_rdata), .in_alu_res(in_alu_res),
        .in_wr_addr(in_wr_addr), .in_jump(in_jump), .in_jump_target(in_jump_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_reg_write(out_reg_write),
        .out_mem_to_reg(out_mem_to_reg), .out_mem_rdata(out_mem_rdata),
        .out_alu_res(out_alu_res), .out_wr_addr(out_wr_addr), .out_jump(out_jump),
        .out_jump_target(out_jump_target),
`ifdef MEMWB_FWD_EN
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
`endif
        .out_wb_data(out_wb_data)
    );

    mem_wb_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .ZERO_REG_SUPPRESS(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(nz_in_ready),
        .in_wb(in_wb), .in_mem_rdata(in_mem_rdata), .in_alu_res(in_alu_res),
        .in_wr_addr(in_wr_addr), .in_jump(in_jump), .in_jump_target(in_jump_target),
        .out_valid(nz_out_valid), .out_ready(out_ready), .out_reg_write(nz_out_reg_write),
        .out_mem_to_reg(nz_out_mem_to_reg), .out_mem_rdata(nz_out_mem_rdata),
        .out_alu_res(nz_out_alu_res), .out_wr_addr(nz_out_wr_addr), .out_jump(nz_out_jump),
        .out_jump_target(nz_out_jump_target),
`ifdef MEMWB_FWD_EN
        .fwd_valid(nz_fwd_valid), .fwd_addr(nz_fwd_addr), .fwd_data(nz_fwd_data),
`endif
        .out_wb_data(nz_out_wb_data)
    );

    // Expected entry as the architecture defines it, from the current inputs.
    function automatic exp_t make_entry();
        exp_t e;
        e.reg_write   = in_wb[0] && (in_wr_addr != 0);
        e.mem_to_reg  = in_wb[1];
        e.mem_rdata   = in_mem_rdata;
        e.alu_res     = in_alu_res;
        e.wr_addr     = in_wr_addr;
        e.jump        = in_jump;
        e.jump_target = in_jump_target;
        e.wb_data     = in_wb[1] ? in_mem_rdata : in_alu_res;
        return e;
    endfunction

    // Advance one clock; the model is a FIFO of capacity two.
    task automatic step();
        bit   acc, cons;
        exp_t e;
        acc  = in_valid && (exp_q.size() < 2);
        cons = (exp_q.size() > 0) && out_ready;
        e    = make_entry();
        @(posedge clk);
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (cons) begin
                $display("xfer out: addr=%0d wb_data=%h rw=%0b", exp_q[0].wr_addr, exp_q[0].wb_data, exp_q[0].reg_write);
                void'(exp_q.pop_front());
            end
            if (acc) exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input bit v, input bit [1:0] wb, input bit [DW-1:0] md,
                         input bit [DW-1:0] alu, input bit [AW-1:0] addr);
        in_valid       = v;
        in_wb          = wb;
        in_mem_rdata   = md;
        in_alu_res     = alu;
        in_wr_addr     = addr;
        in_jump        = $urandom_range(0, 1);
        in_jump_target = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        total++;
        if ({out_reg_write, out_mem_to_reg, out_jump, out_wr_addr, out_mem_rdata, out_alu_res,
             out_jump_target, out_wb_data} !== '0) begin
            bad++; $display("FAIL reset_outputs: got wb_data=%h alu=%h addr=%0d want all 0", out_wb_data, out_alu_res, out_wr_addr);
        end
        rst = 1'b0;
        step();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        drive(1'b1, 2'b01, $urandom, 32'h0000_0010, 5'd3);
        step();
        drive(1'b1, 2'b11, 32'hDEAD_BEEF, $urandom, 5'd4);
        total++;
        if (out_valid !== 1'b1 || out_wb_data !== 32'h10) begin
            bad++; $display("FAIL stream_first: got valid=%b wb=%h want 1 00000010", out_valid, out_wb_data);
        end
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_wb_data !== 32'hDEAD_BEEF || out_wr_addr !== 5'd4) begin
            bad++; $display("FAIL stream_second: got valid=%b wb=%h addr=%0d want 1 deadbeef 4", out_valid, out_wb_data, out_wr_addr);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        bit [DW-1:0] vals[3];
        vals[0] = 32'h111; vals[1] = 32'h222; vals[2] = 32'h333;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b01, $urandom, vals[i], AW'(i + 8));
            step();
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (out_wb_data !== 32'h111 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_stall: got wb=%h valid=%b ready=%b want 111 1 0", out_wb_data, out_valid, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_wb_data !== vals[i] || out_wr_addr !== AW'(i + 8)) begin
                bad++; $display("FAIL bp_order%0d: got valid=%b wb=%h addr=%0d want 1 %h %0d", i, out_valid, out_wb_data, out_wr_addr, vals[i], i + 8);
            end
            step();
            if (i == 1) in_valid = 1'b0;
        end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_nodup: got valid=%b wb=%h want 0", out_valid, out_wb_data); end
    endtask

    task automatic test_zero_reg();
        out_ready = 1'b1;
        drive(1'b1, 2'b01, $urandom, 32'hABCD, 5'd0);
        step();
        in_valid = 1'b0;
        total++;
        if (out_reg_write !== 1'b0 || out_wr_addr !== 5'd0 || out_wb_data !== 32'hABCD) begin
            bad++; $display("FAIL zero_suppress: got rw=%b addr=%0d wb=%h want 0 0 0000abcd", out_reg_write, out_wr_addr, out_wb_data);
        end
        total++;
        if (nz_out_reg_write !== 1'b1) begin bad++; $display("FAIL zero_nosuppress: got rw=%b want 1", nz_out_reg_write); end
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 2'b01, $urandom, 32'hD0, 5'd5);
        step();
        drive(1'b1, 2'b01, $urandom, 32'hE0, 5'd6);
        step();
        drive(1'b1, 2'b01, $urandom, 32'hF0, 5'd7);
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_state: got valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
        for (int i = 0; i < 3; i++) step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped: got valid=%b wb=%h want 0", out_valid, out_wb_data); end
    endtask

    task automatic test_reset_stall();
        for (int k = 0; k < 2; k++) begin
            out_ready = 1'b0;
            drive(1'b1, 2'b11, $urandom | 1, $urandom | 1, 5'd9);
            step();
            step();
            rst = 1'b1;
            flush = (k == 1);
            step();
            rst = 1'b0;
            flush = 1'b0;
            in_valid = 1'b0;
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_wb_data !== '0 ||
                out_mem_rdata !== '0 || out_wr_addr !== '0 || out_reg_write !== 1'b0) begin
                bad++; $display("FAIL reset_stall%0d: got valid=%b ready=%b wb=%h addr=%0d want 0 1 0 0", k, out_valid, in_ready, out_wb_data, out_wr_addr);
            end
        end
    endtask

`ifdef MEMWB_FWD_EN
    task automatic test_fwd();
        out_ready = 1'b0;
        drive(1'b1, 2'b01, $urandom, 32'h55, 5'd7);
        step();
        in_valid = 1'b0;
        total++;
        if (fwd_valid !== 1'b1 || fwd_addr !== 5'd7 || fwd_data !== 32'h55) begin
            bad++; $display("FAIL fwd_on: got v=%b a=%0d d=%h want 1 7 00000055", fwd_valid, fwd_addr, fwd_data);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b1, 2'b00, $urandom, 32'h55, 5'd7);
        step();
        in_valid = 1'b0;
        total++;
        if (fwd_valid !== 1'b0 || fwd_addr !== 5'd7) begin
            bad++; $display("FAIL fwd_off: got v=%b a=%0d want 0 7", fwd_valid, fwd_addr);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask
`endif

    task automatic test_random();
        int seen = 0;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom), $urandom, $urandom, 5'($urandom));
            out_ready = $urandom_range(0, 2) != 0;
            flush = ($urandom_range(0, 39) == 0);
            total++;
            if (out_valid !== (exp_q.size() > 0) || in_ready !== (exp_q.size() < 2)) begin
                bad++; $display("FAIL rand_hs c=%0d: got valid=%b ready=%b want %b %b", c, out_valid, in_ready, exp_q.size() > 0, exp_q.size() < 2);
            end
            if (exp_q.size() > 0) begin
                seen++;
                total++;
                if (out_wb_data !== exp_q[0].wb_data || out_reg_write !== exp_q[0].reg_write ||
                    out_mem_to_reg !== exp_q[0].mem_to_reg || out_wr_addr !== exp_q[0].wr_addr ||
                    out_alu_res !== exp_q[0].alu_res || out_mem_rdata !== exp_q[0].mem_rdata ||
                    out_jump !== exp_q[0].jump || out_jump_target !== exp_q[0].jump_target) begin
                    bad++; $display("FAIL rand_data c=%0d: got wb=%h rw=%b addr=%0d want wb=%h rw=%b addr=%0d", c, out_wb_data, out_reg_write, out_wr_addr, exp_q[0].wb_data, exp_q[0].reg_write, exp_q[0].wr_addr);
                end
            end
            step();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        total++;
        if (seen < 50) begin bad++; $display("FAIL rand_coverage: got %0d head cycles want >=50", seen); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_to_back();
        test_zero_reg();
        test_flush();
        test_reset_stall();
`ifdef MEMWB_FWD_EN
        test_fwd();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
